// File: rtl/compute_unit_scheduler_pkg.sv
// Shared types and width helpers for the compute-unit scheduler.
package compute_unit_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_e;

   // Width of an index into n items (unit pointer, FIFO pointer).
   function automatic int unsigned sched_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold the value n itself.
   function automatic int unsigned sched_cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// Single-clock result FIFO; head is zero while empty so the output is clean after reset.
module sched_result_fifo
   import compute_unit_scheduler_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned resultWidth = 32,
   localparam int unsigned PTR_W = sched_idx_w(FIFO_DEPTH),
   localparam int unsigned CNT_W = sched_cnt_w(FIFO_DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [resultWidth-1:0] push_data_i,
   input  logic                   pop_i,
   output logic [resultWidth-1:0] head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [CNT_W-1:0]       count_o
);

   logic [resultWidth-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic                   do_push;
   logic                   do_pop;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
      $error("sched_result_fifo: FIFO_DEPTH must be a power of two and at least 2");
   end

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push_i && full_o));
      end
   end

endmodule

// File: rtl/compute_unit_scheduler.sv
// Round-robin sample dispatcher with credit-controlled in-order result return.
// Optional perf counters are enabled by defining SCHED_PERF_COUNT_EN.
module compute_unit_scheduler
   import compute_unit_scheduler_pkg::*;
#(
   parameter int unsigned dataSampleWidth = 16,
   parameter int unsigned resultWidth     = 32,
   parameter int unsigned NUM_UNITS       = 4,
   parameter int unsigned UNIT_LATENCY    = 1,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [dataSampleWidth-1:0]           sample_data,
   input  logic                                 sample_valid,
   output logic                                 sample_ready,
   output logic [NUM_UNITS*dataSampleWidth-1:0] unit_sample,
   output logic [NUM_UNITS-1:0]                 unit_load,
   input  logic [NUM_UNITS*resultWidth-1:0]     unit_result,
   output logic [resultWidth-1:0]               result_data,
   output logic                                 result_valid,
   input  logic                                 result_ready,
   output logic                                 idle
`ifdef SCHED_PERF_COUNT_EN
   ,
   output logic [31:0]                          perf_issued,
   output logic [31:0]                          perf_stall,
   output logic [31:0]                          perf_backpressure
`endif
);

   localparam int unsigned IDX_W = sched_idx_w(NUM_UNITS);
   localparam int unsigned CNT_W = sched_cnt_w(FIFO_DEPTH);
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

   if (NUM_UNITS < 2 || UNIT_LATENCY < 1 || NUM_UNITS < UNIT_LATENCY) begin : g_param_err
      $error("compute_unit_scheduler: need NUM_UNITS >= 2, UNIT_LATENCY >= 1, NUM_UNITS >= UNIT_LATENCY");
   end

   sched_state_e state_q, state_d;

   logic [IDX_W-1:0]                     ptr_q, ptr_d;
   logic [NUM_UNITS*dataSampleWidth-1:0] sample_q, sample_d;
   logic [NUM_UNITS-1:0]                 load_q, load_d;
   logic                                 iss_vld_q, iss_vld_d;
   logic [IDX_W-1:0]                     iss_idx_q, iss_idx_d;
   logic [UNIT_LATENCY-1:0]              dl_vld_q;
   logic [IDX_W-1:0]                     dl_idx_q [UNIT_LATENCY];
   logic [CNT_W-1:0]                     inflight_q, inflight_d;

   logic                   accept;
   logic                   ret_vld;
   logic [IDX_W-1:0]       ret_idx;
   logic [resultWidth-1:0] push_data;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;
   logic [CNT_W-1:0]       fifo_cnt_nxt;
   logic [CNT_W:0]         used;

   assign accept    = sample_valid && sample_ready;
   assign ret_vld   = dl_vld_q[UNIT_LATENCY-1];
   assign ret_idx   = dl_idx_q[UNIT_LATENCY-1];
   assign fifo_push = ret_vld;
   assign fifo_pop  = result_valid && result_ready;

   assign unit_sample  = sample_q;
   assign unit_load    = load_q;
   assign result_valid = !fifo_empty;

   assign fifo_cnt_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain completes on the cycle the last result leaves, so idle rises right after that pop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable) begin
               state_d = ST_RUN;
            end else if (inflight_d == '0 && fifo_cnt_nxt == '0) begin
               state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      used         = {1'b0, fifo_count} + {1'b0, inflight_q};
      sample_ready = (state_q == ST_RUN) && !fifo_full && (used < DEPTH_L);
      idle         = (state_q == ST_IDLE) && (inflight_q == '0) && fifo_empty;
   end

   // ---------------- issue ----------------
   always_comb begin
      sample_d  = sample_q;
      load_d    = '0;
      ptr_d     = ptr_q;
      iss_vld_d = accept;
      iss_idx_d = ptr_q;
      if (accept) begin
         for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (ptr_q == IDX_W'(i)) begin
               sample_d[i*dataSampleWidth +: dataSampleWidth] = sample_data;
               load_d[i] = 1'b1;
            end
         end
         ptr_d = (ptr_q == IDX_W'(NUM_UNITS - 1)) ? '0 : ptr_q + IDX_W'(1);
      end
   end

   // ---------------- return ----------------
   always_comb begin
      push_data = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         if (ret_idx == IDX_W'(i)) begin
            push_data = unit_result[i*resultWidth +: resultWidth];
         end
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      if (accept && !ret_vld) begin
         inflight_d = inflight_q + CNT_W'(1);
      end else if (!accept && ret_vld) begin
         inflight_d = inflight_q - CNT_W'(1);
      end
   end

   // Delay line starts at the load pulse, so a stage exits exactly UNIT_LATENCY cycles later.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         sample_q   <= '0;
         load_q     <= '0;
         iss_vld_q  <= 1'b0;
         iss_idx_q  <= '0;
         inflight_q <= '0;
         dl_vld_q   <= '0;
         for (int unsigned k = 0; k < UNIT_LATENCY; k++) begin
            dl_idx_q[k] <= '0;
         end
      end else begin
         ptr_q       <= ptr_d;
         sample_q    <= sample_d;
         load_q      <= load_d;
         iss_vld_q   <= iss_vld_d;
         iss_idx_q   <= iss_idx_d;
         inflight_q  <= inflight_d;
         dl_vld_q[0] <= iss_vld_q;
         dl_idx_q[0] <= iss_idx_q;
         for (int unsigned k = 1; k < UNIT_LATENCY; k++) begin
            dl_vld_q[k] <= dl_vld_q[k-1];
            dl_idx_q[k] <= dl_idx_q[k-1];
         end
      end
   end

   sched_result_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .resultWidth(resultWidth)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (fifo_push),
      .push_data_i(push_data),
      .pop_i      (fifo_pop),
      .head_o     (result_data),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

`ifdef SCHED_PERF_COUNT_EN
   logic [31:0] perf_issued_q;
   logic [31:0] perf_stall_q;
   logic [31:0] perf_bp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
         perf_bp_q     <= '0;
      end else begin
         if (accept && perf_issued_q != '1) begin
            perf_issued_q <= perf_issued_q + 32'd1;
         end
         if (state_q == ST_RUN && sample_valid && !sample_ready && perf_stall_q != '1) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (result_valid && !result_ready && perf_bp_q != '1) begin
            perf_bp_q <= perf_bp_q + 32'd1;
         end
      end
   end

   assign perf_issued       = perf_issued_q;
   assign perf_stall        = perf_stall_q;
   assign perf_backpressure = perf_bp_q;
`endif

endmodule

// File: tb/tb_compute_unit_scheduler.sv
// Directed bench for compute_unit_scheduler; units modelled as registered result = sample << 2.
module tb_compute_unit_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic [63:0] unit_sample;
   logic [3:0]  unit_load;
   logic [127:0] unit_result;
   logic [31:0] result_data;
   logic        result_valid;
   logic        result_ready;
   logic        idle;
`ifdef SCHED_PERF_COUNT_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_stall;
   logic [31:0] perf_backpressure;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] unit_res [4];

   always #5 clk = ~clk;

   compute_unit_scheduler #(
      .dataSampleWidth(16),
      .resultWidth    (32),
      .NUM_UNITS      (4),
      .UNIT_LATENCY   (1),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .unit_sample (unit_sample),
      .unit_load   (unit_load),
      .unit_result (unit_result),
      .result_data (result_data),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .idle        (idle)
`ifdef SCHED_PERF_COUNT_EN
      ,
      .perf_issued      (perf_issued),
      .perf_stall       (perf_stall),
      .perf_backpressure(perf_backpressure)
`endif
   );

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) unit_res[i] <= '0;
         else if (unit_load[i]) unit_res[i] <= 32'(unit_sample[i*16 +: 16]) << 2;
      end
   end
   assign unit_result = {unit_res[3], unit_res[2], unit_res[1], unit_res[0]};

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0; result_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_run(input logic rr);
      enable = 1'b1; result_ready = rr;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", sample_ready); end
      total++; if (unit_load !== 4'b0) begin bad++; $display("FAIL reset_load got=%b exp=0000", unit_load); end
      total++; if (unit_sample !== 64'b0) begin bad++; $display("FAIL reset_sample got=%h exp=0", unit_sample); end
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", result_valid); end
      total++; if (result_data !== 32'b0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", result_data); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
   endtask

   task automatic test_streaming();
      logic [3:0] exp_load;
      logic       exp_rv;
      do_reset();
      start_run(1'b1);
      for (int n = 0; n <= 8; n++) begin
         exp_load = (n >= 1 && n <= 5) ? 4'(1 << ((n - 1) % 4)) : 4'b0;
         total++; if (unit_load !== exp_load) begin bad++; $display("FAIL stream_load n=%0d got=%b exp=%b", n, unit_load, exp_load); end
         if (n >= 1 && n <= 5) begin
            total++;
            if (unit_sample[((n - 1) % 4)*16 +: 16] !== 16'(n)) begin
               bad++; $display("FAIL stream_slice n=%0d got=%h exp=%h", n, unit_sample[((n - 1) % 4)*16 +: 16], 16'(n));
            end
         end
         exp_rv = (n >= 3 && n <= 7);
         total++; if (result_valid !== exp_rv) begin bad++; $display("FAIL stream_rvalid n=%0d got=%b exp=%b", n, result_valid, exp_rv); end
         if (exp_rv) begin
            total++; if (result_data !== 32'(4 * (n - 2))) begin bad++; $display("FAIL stream_rdata n=%0d got=%0d exp=%0d", n, result_data, 4 * (n - 2)); end
         end
         if (n < 5) begin
            total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL stream_ready n=%0d got=%b exp=1", n, sample_ready); end
            sample_data = 16'(n + 1); sample_valid = 1'b1;
         end else begin
            sample_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int pops = 0;
      do_reset();
      start_run(1'b0);
      for (int n = 0; n <= 9; n++) begin
         if (n >= 3) begin
            total++;
            if ({result_valid, result_data} !== {1'b1, 32'd4}) begin
               bad++; $display("FAIL bp_hold n=%0d got=%b/%0d exp=1/4", n, result_valid, result_data);
            end
         end
         sample_valid = 1'b1; sample_data = 16'(acc + 1);
         total++; if (sample_ready !== (n < 4)) begin bad++; $display("FAIL bp_ready n=%0d got=%b exp=%b", n, sample_ready, (n < 4)); end
         if (sample_ready) acc++;
         @(negedge clk);
      end
      total++; if (acc != 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
      result_ready = 1'b1;
      for (int n = 10; n <= 29; n++) begin
         if (acc < 6) begin sample_valid = 1'b1; sample_data = 16'(acc + 1); end
         else sample_valid = 1'b0;
         if (sample_ready && sample_valid) acc++;
         if (result_valid) begin
            total++; if (result_data !== 32'(4 * (pops + 1))) begin bad++; $display("FAIL bp_order pop=%0d got=%0d exp=%0d", pops, result_data, 4 * (pops + 1)); end
            pops++;
         end
         @(negedge clk);
      end
      sample_valid = 1'b0;
      total++; if (acc != 6) begin bad++; $display("FAIL bp_resume got=%0d exp=6", acc); end
      total++; if (pops != 6) begin bad++; $display("FAIL bp_pops got=%0d exp=6", pops); end
`ifdef SCHED_PERF_COUNT_EN
      total++; if (perf_issued !== 32'd6) begin bad++; $display("FAIL perf_issued got=%0d exp=6", perf_issued); end
      total++; if (perf_stall !== 32'd7) begin bad++; $display("FAIL perf_stall got=%0d exp=7", perf_stall); end
      total++; if (perf_backpressure !== 32'd7) begin bad++; $display("FAIL perf_bp got=%0d exp=7", perf_backpressure); end
`endif
   endtask

   task automatic test_drain();
      logic exp_rv;
      do_reset();
      start_run(1'b1);
      for (int n = 0; n <= 7; n++) begin
         if (n < 3) begin
            total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL drain_ready n=%0d got=%b exp=1", n, sample_ready); end
            sample_valid = 1'b1; sample_data = 16'(n + 1);
         end else if (n == 3) begin
            enable = 1'b0; sample_valid = 1'b0;
         end else begin
            sample_valid = 1'b1; sample_data = 16'h0099;
            total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL drain_noaccept n=%0d got=%b exp=0", n, sample_ready); end
            total++; if (unit_load !== 4'b0) begin bad++; $display("FAIL drain_noload n=%0d got=%b exp=0000", n, unit_load); end
         end
         exp_rv = (n >= 3 && n <= 5);
         total++; if (result_valid !== exp_rv) begin bad++; $display("FAIL drain_rvalid n=%0d got=%b exp=%b", n, result_valid, exp_rv); end
         if (exp_rv) begin
            total++; if (result_data !== 32'(4 * (n - 2))) begin bad++; $display("FAIL drain_rdata n=%0d got=%0d exp=%0d", n, result_data, 4 * (n - 2)); end
         end
         total++; if (idle !== (n >= 6)) begin bad++; $display("FAIL drain_idle n=%0d got=%b exp=%b", n, idle, (n >= 6)); end
         @(negedge clk);
      end
      sample_valid = 1'b0;
   endtask

   task automatic test_simultaneous();
      int acc = 0;
      int pops = 0;
      logic [3:0] exp_load;
      do_reset();
      start_run(1'b0);
      for (int n = 0; n <= 30; n++) begin
         if (n == 7) result_ready = 1'b1;
         sample_valid = 1'b1; sample_data = 16'(acc + 1);
         if (n == 6) begin
            total++;
            if ({sample_ready, result_valid} !== 2'b01) begin
               bad++; $display("FAIL simul_full ready/rvalid got=%b%b exp=01", sample_ready, result_valid);
            end
         end
         if (n >= 8) begin
            total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL simul_ready n=%0d got=%b exp=1", n, sample_ready); end
            total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL simul_rvalid n=%0d got=%b exp=1", n, result_valid); end
         end
         if (n >= 9) begin
            exp_load = 4'(1 << ((acc - 1) % 4));
            total++; if (unit_load !== exp_load) begin bad++; $display("FAIL simul_load n=%0d got=%b exp=%b", n, unit_load, exp_load); end
         end
         if (sample_ready) acc++;
         if (result_ready && result_valid) begin
            total++; if (result_data !== 32'(4 * (pops + 1))) begin bad++; $display("FAIL simul_rdata pop=%0d got=%0d exp=%0d", pops, result_data, 4 * (pops + 1)); end
            pops++;
         end
         @(negedge clk);
      end
      sample_valid = 1'b0;
      total++; if (acc != 27) begin bad++; $display("FAIL simul_issues got=%0d exp=27", acc); end
      total++; if (pops != 24) begin bad++; $display("FAIL simul_pops got=%0d exp=24", pops); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_run(1'b0);
      for (int n = 0; n < 4; n++) begin
         sample_valid = 1'b1; sample_data = 16'(n + 1);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      total++; if ({result_valid, idle} !== 2'b10) begin bad++; $display("FAIL midrst_busy rvalid/idle got=%b%b exp=10", result_valid, idle); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid got=%b exp=0", result_valid); end
      total++; if (result_data !== 32'b0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", result_data); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b exp=1", idle); end
      total++; if (unit_sample !== 64'b0) begin bad++; $display("FAIL midrst_sample got=%h exp=0", unit_sample); end
      reset = 1'b0; enable = 1'b1; result_ready = 1'b1;
      @(negedge clk);
      total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", sample_ready); end
      sample_valid = 1'b1; sample_data = 16'h0055;
      @(negedge clk);
      sample_valid = 1'b0;
      total++; if (unit_load !== 4'b0001) begin bad++; $display("FAIL midrst_ptr0 got=%b exp=0001", unit_load); end
      total++; if (unit_sample[15:0] !== 16'h0055) begin bad++; $display("FAIL midrst_slice0 got=%h exp=0055", unit_sample[15:0]); end
      @(negedge clk);
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL midrst_nostale got=%b exp=0", result_valid); end
      @(negedge clk);
      total++;
      if ({result_valid, result_data} !== {1'b1, 32'h154}) begin
         bad++; $display("FAIL midrst_result got=%b/%h exp=1/154", result_valid, result_data);
      end
      @(negedge clk);
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL midrst_popped got=%b exp=0", result_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_drain();
      test_simultaneous();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/compute_unit_scheduler.md
Name: compute_unit_scheduler

Overview:
- Round-robin dispatcher between one upstream sample stream and NUM_UNITS compute units in the scalable top.
- Loads each sample into the next unit's input register, tracks the fixed unit latency, and captures that unit's result.
- Returns results in issue order on a valid/ready output backed by a credit-controlled result FIFO.
- Enable/drain control lets the top quiesce the compute array.

Parameters:
- dataSampleWidth, 16, width of one sample.
- resultWidth, 32, width of one unit result.
- NUM_UNITS, 4, number of compute units served; must be ≥ 2.
- UNIT_LATENCY, 1, cycles from the unit_load pulse to a valid result on that unit's slice; must be ≥ 1.
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = accept samples; 0 = stop accepting and drain.
- sample_data  in  dataSampleWidth  upstream sample.
- sample_valid  in  1  upstream valid.
- sample_ready  out  1  upstream ready.
- unit_sample  out  NUM_UNITS*dataSampleWidth  per-unit held sample; unit i occupies slice i.
- unit_load  out  NUM_UNITS  one-hot pulse marking a new sample on unit i.
- unit_result  in  NUM_UNITS*resultWidth  per-unit results; slice i belongs to unit i.
- result_data  out  resultWidth  head of result FIFO.
- result_valid  out  1  FIFO not empty.
- result_ready  in  1  downstream accept.
- idle  out  1  state IDLE, nothing outstanding, FIFO empty.

Behaviour:
- Reset values:
  - unit_sample all 0, unit_load 0, sample_ready 0, result_valid 0, result_data 0, idle 1.
  - Round-robin pointer 0, FIFO empty, in-flight count 0, state IDLE.
- FSM states and transitions:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN → RUN if enable returns to 1.
  - DRAIN → IDLE when in_flight=0 and the FIFO is empty.
- Credit rule:
  - credits = FIFO_DEPTH − fifo_count − in_flight.
  - sample_ready = (state==RUN) && credits>0. It is registered-free combinational from state and counters, not from sample_valid.
- Issue:
  - On sample_valid && sample_ready, the unit_sample slice at the pointer gets sample_data and unit_load[ptr] pulses for 1 cycle.
  - The pointer then advances, wrapping NUM_UNITS−1 → 0.
  - Slices hold their value until that unit's next load.
- Return tracking:
  - A delay line of UNIT_LATENCY stages carries {valid, unit index}.
  - When a stage exits valid, the unit_result slice for that index is written into the FIFO the same cycle, and in_flight decrements.
- Ordering:
  - Fixed latency plus round-robin guarantees in-order results.
  - A given unit is reused only every NUM_UNITS issues; NUM_UNITS ≥ UNIT_LATENCY is required so a unit's sample is not overwritten while its result is pending. Enforce this with an elaboration check.
- Simultaneous events:
  - An issue and a return in the same cycle leave in_flight unchanged.
  - A FIFO push and pop in the same cycle leave count unchanged. Pop on empty is impossible (result_valid=0).
  - The credit scheme means the FIFO can never overflow; add an assertion on push when full.
- Output stream: result_data/result_valid come from the FIFO head. Once valid, data is stable until result_ready.
- enable drop mid-burst: no new issue from the next cycle. Outstanding results still land and drain; idle rises only after the last pop.
- Reset mid-operation: all in-flight results and FIFO contents are discarded and the pointer returns to 0.

Optional Feature:
- Macro SCHED_PERF_COUNT_EN.
- When defined, add three outputs:
  - perf_issued (32 bits): count of accepted samples.
  - perf_stall (32 bits): cycles with sample_valid && !sample_ready while in RUN.
  - perf_backpressure (32 bits): cycles with result_valid && !result_ready.
- All three clear on reset and saturate at all-ones.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state typedef (IDLE/RUN/DRAIN), and the clog2-based widths for pointer, count and unit index.
- Natural sub-module: sched_result_fifo, a synchronous single-clock FIFO with push/pop/full/empty/count outputs and FIFO_DEPTH/resultWidth parameters.

Test Plan (NUM_UNITS=4, UNIT_LATENCY=1, FIFO_DEPTH=4, units modelled as result = sample<<2):
- Streaming:
  - Stimulus: enable=1, result_ready=1, samples 1,2,3,4,5 back-to-back.
  - Response: unit_load = 0001,0010,0100,1000,0001; results 4,8,12,16,20 in order; each result_valid 2 cycles after its accept.
- Backpressure:
  - Stimulus: result_ready=0, 6 samples offered.
  - Response: exactly 4 accepted, then sample_ready=0; result_ready=1 releases 4,8,12,16 and resumes issue.
- Drain:
  - Stimulus: 3 samples accepted, enable=0 on the cycle after the last accept, result_ready=1.
  - Response: no further accepts; 3 results delivered; idle=1 the cycle after the final pop.
- Simultaneous:
  - Stimulus: full FIFO, result_ready=1 and sample_valid=1 steady.
  - Response: one pop and one issue per cycle sustained, FIFO count stays constant, no overflow assertion.
- Reset mid-run:
  - Stimulus: reset pulsed with 2 in flight and 2 queued.
  - Response: result_valid=0, idle=1, pointer=0; the next sample loads unit 0.
- SCHED_PERF_COUNT_EN:
  - Stimulus: rerun the backpressure scenario with the macro defined.
  - Response: perf_issued=6, perf_stall=number of cycles the 5th/6th samples waited, perf_backpressure=cycles held off.
